// File: rtl/gpu_command_master.sv
// GPU command bus master: accepts host command requests and replays them on a
// strobed parallel bus (chip select, command/data pins, commandClk strobe),
// with burst support, gpuBusy flow control and read-data return.
// Optional feature macro: CMD_TIMEOUT_EN (gpuBusy wait timeout with errTimeout).
module gpu_command_master #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned TURNAROUND     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        hostClk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [15:0] reqCommand,
  input  logic [15:0] reqData,
  input  logic [7:0]  reqBurstLen,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        errCmd,
  output logic        errTimeout,
  input  logic        gpuBusy,
  output logic        chipSelect,
  output logic        outputEnable,
  output logic        commandClk,
  output logic [15:0] commandOut,
  output logic [15:0] dataOut,
  output logic        dataOe,
  input  logic [15:0] dataIn
);

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, HIGH, TURN} state_t;

  localparam logic [1:0] TYPE_RESET = 2'b00;
  localparam logic [1:0] TYPE_READ  = 2'b01;
  localparam logic [1:0] TYPE_WRITE = 2'b10;
  localparam logic [1:0] TYPE_RSVD  = 2'b11;
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] TURN_LAST  = 8'(TURNAROUND - 1);

  state_t      state_q, state_n;
  logic [15:0] cmd_q;
  logic [15:0] data_q;
  logic [7:0]  beats_q;     // beats still to run, including the current one
  logic [7:0]  phase_q;     // cycles spent in the current state
  logic        mid_burst_q; // at least one beat of this burst already done
  logic        busy_meta, busy_sync;
  logic        high_last;
  logic        is_read, is_write;

  assign is_read    = (cmd_q[15:14] == TYPE_READ);
  assign is_write   = (cmd_q[15:14] == TYPE_WRITE);
  assign commandOut = cmd_q;
  assign dataOut    = data_q;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_q;
  logic            timeout_hit;
`else
  assign errTimeout = 1'b0;
`endif

  // Next-state decode and Moore bus outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n      = state_q;
    high_last    = 1'b0;
    reqReady     = 1'b0;
    chipSelect   = 1'b1;
    outputEnable = 1'b1;
    commandClk   = 1'b0;
    dataOe       = 1'b0;
`ifdef CMD_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) state_n = WAIT;
      end
      WAIT: begin
        // Between beats the bus stays selected and a read keeps the GPU driving.
        chipSelect   = ~mid_burst_q;
        outputEnable = ~(mid_burst_q & is_read);
        if (cmd_q[15:14] == TYPE_RSVD) state_n = IDLE;
        else if (!busy_sync) state_n = SETUP;
`ifdef CMD_TIMEOUT_EN
        else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_n     = TURN;
        end
`endif
      end
      SETUP: begin
        chipSelect   = 1'b0;
        outputEnable = ~is_read;
        dataOe       = is_write;
        if (phase_q == DIV_LAST) state_n = HIGH;
      end
      HIGH: begin
        chipSelect   = 1'b0;
        outputEnable = ~is_read;
        dataOe       = is_write;
        commandClk   = 1'b1;
        if (phase_q == DIV_LAST) begin
          high_last = 1'b1;
          state_n   = (beats_q == 8'd1) ? TURN : WAIT;
        end
      end
      TURN: begin
        if (phase_q == TURN_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and response registers.
  always_ff @(posedge hostClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      beats_q     <= '0;
      phase_q     <= '0;
      mid_burst_q <= 1'b0;
      busy_meta   <= 1'b0;
      busy_sync   <= 1'b0;
      rspValid    <= 1'b0;
      rspData     <= '0;
      errCmd      <= 1'b0;
    end else begin
      state_q   <= state_n;
      phase_q   <= (state_n != state_q) ? 8'd0 : phase_q + 8'd1;
      busy_meta <= gpuBusy;
      busy_sync <= busy_meta;
      rspValid  <= 1'b0;
      errCmd    <= 1'b0;
      if (state_q == IDLE && reqValid) begin
        cmd_q       <= reqCommand;
        data_q      <= reqData;
        mid_burst_q <= 1'b0;
        errCmd      <= (reqCommand[15:14] == TYPE_RSVD);
        if (reqCommand[15:14] == TYPE_RESET || reqBurstLen == 8'd0) beats_q <= 8'd1;
        else beats_q <= reqBurstLen;
      end
      // Host presents the next burst word before each follow-on beat.
      if (state_q == WAIT && state_n == SETUP && mid_burst_q) data_q <= reqData;
      if (high_last) begin
        beats_q     <= beats_q - 8'd1;
        mid_burst_q <= 1'b1;
        if (is_read) begin
          rspData  <= dataIn;
          rspValid <= 1'b1;
        end
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Count stalled WAIT cycles; cleared whenever WAIT is entered or left.
  always_ff @(posedge hostClk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      errTimeout <= 1'b0;
    end else begin
      errTimeout <= timeout_hit;
      if (state_q == WAIT && state_n == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      else wait_cnt_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_command_master.sv
// Self-checking bench for gpu_command_master: directed scenarios plus
// randomized read/write bursts checked against per-transaction expected
// beat/response sequences. Optional CMD_TIMEOUT_EN section.
module tb_gpu_command_master;

  localparam int CLK_DIV    = 2;
  localparam int TURNAROUND = 1;
  localparam int TIMEOUT    = 16;

  logic        hostClk = 1'b0;
  logic        rst, reqValid, reqReady, rspValid, errCmd, errTimeout, gpuBusy;
  logic        chipSelect, outputEnable, commandClk, dataOe;
  logic [15:0] reqCommand, reqData, rspData, commandOut, dataOut, dataIn;
  logic [7:0]  reqBurstLen;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [15:0] wr_words [256];
  logic [15:0] rd_words [256];

  gpu_command_master #(
    .CLK_DIV(CLK_DIV), .TURNAROUND(TURNAROUND), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .hostClk(hostClk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqCommand(reqCommand), .reqData(reqData), .reqBurstLen(reqBurstLen),
    .rspValid(rspValid), .rspData(rspData), .errCmd(errCmd), .errTimeout(errTimeout),
    .gpuBusy(gpuBusy), .chipSelect(chipSelect), .outputEnable(outputEnable),
    .commandClk(commandClk), .commandOut(commandOut), .dataOut(dataOut),
    .dataOe(dataOe), .dataIn(dataIn)
  );

  always #5 hostClk = ~hostClk;
  always @(posedge hostClk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [55:0] out_vec();
    return {reqReady, rspValid, rspData, errCmd, errTimeout, chipSelect,
            outputEnable, commandClk, commandOut, dataOut, dataOe};
  endfunction

  localparam logic [55:0] RESET_VEC = {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1,
                                       1'b1, 1'b0, 16'h0, 16'h0, 1'b0};

  function automatic void fill_words();
    for (int i = 0; i < 256; i++) begin
      wr_words[i] = 16'($urandom);
      rd_words[i] = 16'($urandom);
    end
  endfunction

  // One request: expected beats/responses derived from the command rules.
  task automatic run_txn(input string tag, input logic [15:0] cmd, input logic [7:0] len,
                         input int stall_beat, input int stall_len, output int cs_low);
    int n, rises, rsps, viol, errs, stall_age, t_acc;
    bit is_rd, is_wr, prev_cclk, done;
    n     = (cmd[15:14] == 2'b00 || len == 8'd0) ? 1 : int'(len);
    is_rd = (cmd[15:14] == 2'b01);
    is_wr = (cmd[15:14] == 2'b10);
    rises = 0; rsps = 0; viol = 0; errs = 0; stall_age = 0;
    prev_cclk = 1'b0; done = 1'b0; cs_low = 0;
    @(negedge hostClk);
    check({tag, "/ready"}, reqReady, 1);
    reqValid = 1'b1; reqCommand = cmd; reqData = wr_words[0];
    reqBurstLen = len; dataIn = rd_words[0];
    @(posedge hostClk);
    @(negedge hostClk);
    reqValid = 1'b0;
    t_acc = cyc;
    for (int c = 0; c < 4000 && !done; c++) begin
      if (c > 0) @(negedge hostClk);
      if (commandClk && !prev_cclk) begin
        if (rises == 0) check({tag, "/first_rise"}, cyc - t_acc, 1 + CLK_DIV);
        check({tag, "/beat"},
              {chipSelect, outputEnable, dataOe, commandOut, is_wr ? dataOut : 16'h0},
              {1'b0, !is_rd, is_wr, cmd, is_wr ? wr_words[rises] : 16'h0});
        rises++;
        if (rises < 256) reqData = wr_words[rises];
        if (rises == stall_beat) begin
          gpuBusy = 1'b1;
          stall_age = 0;
        end
      end else if (gpuBusy) begin
        stall_age++;
        if (stall_age >= CLK_DIV && (commandClk || chipSelect)) viol++;
        if (stall_age >= stall_len) gpuBusy = 1'b0;
      end
      if (rspValid) begin
        check({tag, "/rsp"}, rspData, (rsps < 256) ? rd_words[rsps] : 16'h0);
        rsps++;
        if (rsps < 256) dataIn = rd_words[rsps];
      end
      if (!chipSelect) cs_low++;
      if (!outputEnable && dataOe) viol++;
      if (!chipSelect && (outputEnable == is_rd)) viol++;
      if (is_rd && dataOe) viol++;
      if (errCmd || errTimeout) errs++;
      prev_cclk = commandClk;
      if (reqReady) done = 1'b1;
    end
    gpuBusy = 1'b0;
    check({tag, "/done"}, done, 1);
    check({tag, "/beats"}, rises, n);
    check({tag, "/rsps"}, rsps, is_rd ? n : 0);
    check({tag, "/bus_rules"}, viol, 0);
    check({tag, "/no_err"}, errs, 0);
  endtask

  initial begin
    int cs_low, rises, bad, errs, ready_at, t_acc, to_at;
    logic [1:0] typ;
    logic [7:0] len;
    int n, sb;

    rst = 1'b1; reqValid = 1'b0; reqCommand = '0; reqData = '0;
    reqBurstLen = '0; gpuBusy = 1'b0; dataIn = '0;
    repeat (3) @(posedge hostClk);
    @(negedge hostClk);
    check("reset_outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    fill_words();

    // Single-beat write: strobe timing and chip-select window.
    wr_words[0] = 16'hBEEF;
    run_txn("wr1", 16'h9000, 8'd1, -1, 0, cs_low);
    check("wr1/cs_low_cycles", cs_low, 2 * CLK_DIV);

    // Three-beat read with known data.
    rd_words[0] = 16'h0001; rd_words[1] = 16'h0002; rd_words[2] = 16'h0003;
    run_txn("rd3", 16'h5000, 8'd3, -1, 0, cs_low);

    // Two-beat write with a 10-cycle gpuBusy stall before beat 2.
    fill_words();
    run_txn("wr_stall", 16'h9A5A, 8'd2, 1, 10, cs_low);

    // Reset-type command is always one beat; length 0 means one beat.
    run_txn("type00", 16'h0123, 8'd5, -1, 0, cs_low);
    run_txn("len0", 16'h87FF, 8'd0, -1, 0, cs_low);

    // Maximum burst length runs exactly 255 beats.
    fill_words();
    run_txn("rd255", 16'h4321, 8'd255, -1, 0, cs_low);

`ifndef CMD_TIMEOUT_EN
    // Without the timeout option, a long stall simply waits.
    run_txn("long_stall", 16'hA001, 8'd2, 1, 40, cs_low);
`endif

    // Randomized read/write bursts with optional inter-beat stalls.
    for (int i = 0; i < 12; i++) begin
      fill_words();
      typ = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      len = 8'($urandom_range(0, 5));
      n   = (len == 8'd0) ? 1 : int'(len);
      sb  = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
      run_txn($sformatf("rand%0d", i), {typ, 14'($urandom)}, len, sb,
              int'($urandom_range(3, 9)), cs_low);
    end

    // Reserved command type: error pulse, no bus activity, quick return to ready.
    @(negedge hostClk);
    reqValid = 1'b1; reqCommand = 16'hC000; reqBurstLen = 8'd1;
    @(posedge hostClk);
    @(negedge hostClk);
    reqValid = 1'b0;
    errs = 0; bad = 0; ready_at = 99;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge hostClk);
      if (errCmd) errs++;
      if (!chipSelect || commandClk) bad++;
      if (reqReady && ready_at == 99) ready_at = c + 1;
    end
    check("rsvd/err_pulses", errs, 1);
    check("rsvd/no_bus", bad, 0);
    check("rsvd/ready_within_2", ready_at <= 2, 1);

    // Reset while beat 2 of a 4-beat read is in its HIGH phase.
    @(negedge hostClk);
    reqValid = 1'b1; reqCommand = 16'h5000; reqBurstLen = 8'd4;
    @(posedge hostClk);
    @(negedge hostClk);
    reqValid = 1'b0;
    rises = 0;
    for (int c = 0; c < 200 && rises < 2; c++) begin
      @(negedge hostClk);
      if (commandClk) begin
        rises++;
        if (rises < 2) while (commandClk) @(negedge hostClk);
      end
    end
    check("rst_mid/reached_beat2", rises, 2);
    rst = 1'b1;
    @(posedge hostClk);
    @(negedge hostClk);
    check("rst_mid/outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge hostClk);
      if (rspValid || commandClk || errCmd || errTimeout || !chipSelect) bad++;
    end
    check("rst_mid/quiet", bad, 0);

`ifdef CMD_TIMEOUT_EN
    // gpuBusy stuck high: timeout after TIMEOUT stalled WAIT cycles.
    gpuBusy = 1'b1;
    repeat (3) @(negedge hostClk);
    reqValid = 1'b1; reqCommand = 16'h9000; reqBurstLen = 8'd2;
    @(posedge hostClk);
    @(negedge hostClk);
    reqValid = 1'b0;
    t_acc = cyc; to_at = -1; errs = 0; bad = 0; ready_at = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge hostClk);
      if (errTimeout) begin
        errs++;
        if (to_at < 0) to_at = cyc - t_acc;
        if (!chipSelect) bad++;
      end
      if (commandClk) bad++;
      if (reqReady) ready_at = 1;
    end
    gpuBusy = 1'b0;
    check("timeout/when", to_at, TIMEOUT);
    check("timeout/pulses", errs, 1);
    check("timeout/no_strobe", bad, 0);
    check("timeout/back_idle", ready_at, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
